// File: rtl/wb_commit_checker_pkg.sv
// Shared types and helpers for the write-back commit checker.
package checker_pkg;

  localparam int XLEN_C       = 32;
  localparam int REG_ADDR_W_C = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  typedef struct packed {
    logic [REG_ADDR_W_C-1:0] rd;
    logic [XLEN_C-1:0]       data;
  } commit_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val == max_v) ? val : (val + 64'd1);
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO holding expected commits; head is presented combinationally.
module commit_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == {(AW+1){1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit_checker.sv
// In-flight checker comparing MEM/WB register writes against a buffered
// expected-commit stream, with first-failure capture and run statistics.
module wb_commit_checker import checker_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [REG_ADDR_W-1:0] exp_rd,
  input  logic [XLEN-1:0]       exp_data,
  input  logic                  exp_last,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      mismatch_count,
  output logic [CNT_W-1:0]      commit_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic                  fail_valid,
  output logic [REG_ADDR_W-1:0] fail_rd,
  output logic [XLEN-1:0]       fail_exp,
  output logic [XLEN-1:0]       fail_act
);

  localparam int EW = REG_ADDR_W + XLEN;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] IDLE_ONE   = TW'(1);
  localparam logic [CW-1:0] ONE_LEFT   = CW'(1);

  chk_state_t            state_q;
  logic                  last_q;
  logic                  timeout_q;
  logic [TW-1:0]         idle_q;
  logic [CNT_W-1:0]      mismatch_q, commit_q, cycle_q, stall_q, flush_q;
  logic                  fail_valid_q;
  logic [REG_ADDR_W-1:0] fail_rd_q;
  logic [XLEN-1:0]       fail_exp_q, fail_act_q;

  logic                  push_s, pop_s, full_s, empty_s;
  logic [EW-1:0]         head_s;
  logic [CW-1:0]         fifo_count_s;
  logic [REG_ADDR_W-1:0] head_rd_s;
  logic [XLEN-1:0]       head_data_s, exp_cmp_s;
  logic                  chk_s, mis_s, done_go_s, idle_hit_s;

  commit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({exp_rd, exp_data}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count_s)
  );

  assign exp_ready   = !full_s;
  assign push_s      = exp_valid && exp_ready;
  assign head_rd_s   = head_s[EW-1 -: REG_ADDR_W];
  assign head_data_s = head_s[XLEN-1:0];
  assign exp_cmp_s   = empty_s ? {XLEN{1'b0}} : head_data_s;

  // Writes to x0 never reach the comparator; an empty FIFO makes any commit unexpected.
  assign chk_s      = (state_q == RUN) && wb_valid && (wb_rd != {REG_ADDR_W{1'b0}});
  assign pop_s      = chk_s && !empty_s;
  assign mis_s      = chk_s && (empty_s || (head_rd_s != wb_rd) || (head_data_s != wb_data));
  assign done_go_s  = last_q && !push_s && (empty_s ? !chk_s : (pop_s && (fifo_count_s == ONE_LEFT)));
  assign idle_hit_s = !chk_s && !empty_s && (idle_q >= TIMEOUT_M1);

  assign done           = (state_q == DONE);
  assign pass           = done && !fail_valid_q && !timeout_q;
  assign timeout        = timeout_q;
  assign mismatch_count = mismatch_q;
  assign commit_count   = commit_q;
  assign cycle_count    = cycle_q;
  assign stall_count    = stall_q;
  assign flush_count    = flush_q;
  assign fail_valid     = fail_valid_q;
  assign fail_rd        = fail_rd_q;
  assign fail_exp       = fail_exp_q;
  assign fail_act       = fail_act_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      timeout_q    <= 1'b0;
      idle_q       <= {TW{1'b0}};
      mismatch_q   <= {CNT_W{1'b0}};
      commit_q     <= {CNT_W{1'b0}};
      cycle_q      <= {CNT_W{1'b0}};
      stall_q      <= {CNT_W{1'b0}};
      flush_q      <= {CNT_W{1'b0}};
      fail_valid_q <= 1'b0;
      fail_rd_q    <= {REG_ADDR_W{1'b0}};
      fail_exp_q   <= {XLEN{1'b0}};
      fail_act_q   <= {XLEN{1'b0}};
    end else begin
      if (exp_last) last_q <= 1'b1;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            timeout_q    <= 1'b0;
            idle_q       <= {TW{1'b0}};
            mismatch_q   <= {CNT_W{1'b0}};
            commit_q     <= {CNT_W{1'b0}};
            cycle_q      <= {CNT_W{1'b0}};
            stall_q      <= {CNT_W{1'b0}};
            flush_q      <= {CNT_W{1'b0}};
            fail_valid_q <= 1'b0;
            fail_rd_q    <= {REG_ADDR_W{1'b0}};
            fail_exp_q   <= {XLEN{1'b0}};
            fail_act_q   <= {XLEN{1'b0}};
          end
        end
        RUN: begin
          cycle_q <= CNT_W'(sat_inc(64'(cycle_q), CNT_W));
          if (stall) stall_q  <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
          if (flush) flush_q  <= CNT_W'(sat_inc(64'(flush_q), CNT_W));
          if (pop_s) commit_q <= CNT_W'(sat_inc(64'(commit_q), CNT_W));
          if (mis_s) begin
            mismatch_q <= CNT_W'(sat_inc(64'(mismatch_q), CNT_W));
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_rd_q    <= wb_rd;
              fail_exp_q   <= exp_cmp_s;
              fail_act_q   <= wb_data;
            end
          end
          if (chk_s) idle_q <= {TW{1'b0}};
          else if (idle_q != TIMEOUT_C) idle_q <= idle_q + IDLE_ONE;
          if (done_go_s) begin
            state_q <= DONE;
          end else if (idle_hit_s) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed bench for wb_commit_checker with hand-computed expectations.
module tb_wb_commit_checker;
  import checker_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, exp_valid, exp_ready, exp_last;
  logic [4:0]  exp_rd, wb_rd, fail_rd;
  logic [31:0] exp_data, wb_data, fail_exp, fail_act;
  logic        wb_valid, stall, flush, done, pass, timeout, fail_valid;
  logic [31:0] mismatch_count, commit_count, cycle_count, stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_commit_checker dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd),
    .exp_data(exp_data), .exp_last(exp_last),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .done(done), .pass(pass), .timeout(timeout),
    .mismatch_count(mismatch_count), .commit_count(commit_count),
    .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count),
    .fail_valid(fail_valid), .fail_rd(fail_rd), .fail_exp(fail_exp), .fail_act(fail_act)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input commit_t c);
    exp_valid = 1'b1; exp_rd = c.rd; exp_data = c.data;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; exp_last = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
    exp_last = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    stall = 1'b0; flush = 1'b0;
    repeat (3) tick();
    check("rst_exp_ready", exp_ready, 64'd1);
    check("rst_done", done, 64'd0);
    check("rst_pass", pass, 64'd0);
    check("rst_fail_valid", fail_valid, 64'd0);
    check("rst_cycle", cycle_count, 64'd0);
    reset = 1'b0;
    tick();

    // 1: three matching commits
    exp_last = 1'b1;
    push('{rd: 5'd1, data: 32'd1});
    push('{rd: 5'd2, data: 32'd2});
    push('{rd: 5'd3, data: 32'd3});
    pulse_start();
    commit(5'd1, 32'd1);
    commit(5'd2, 32'd2);
    check("t1_not_done_yet", done, 64'd0);
    commit(5'd3, 32'd3);
    check("t1_done", done, 64'd1);
    check("t1_pass", pass, 64'd1);
    check("t1_commits", commit_count, 64'd3);
    check("t1_mismatch", mismatch_count, 64'd0);
    check("t1_fail_valid", fail_valid, 64'd0);
    check("t1_cycles", cycle_count, 64'd3);

    // 2: data mismatch, restarted from DONE
    push('{rd: 5'd5, data: 32'd6});
    pulse_start();
    check("t2_running", done, 64'd0);
    commit(5'd5, 32'd7);
    check("t2_done", done, 64'd1);
    check("t2_pass", pass, 64'd0);
    check("t2_mismatch", mismatch_count, 64'd1);
    check("t2_fail_valid", fail_valid, 64'd1);
    check("t2_fail_rd", fail_rd, 64'd5);
    check("t2_fail_exp", fail_exp, 64'd6);
    check("t2_fail_act", fail_act, 64'd7);
    check("t2_commits", commit_count, 64'd1);
    check("t2_cycles", cycle_count, 64'd1);

    // 3: x0 write interleaved is ignored; commits in DONE ignored
    push('{rd: 5'd1, data: 32'd10});
    push('{rd: 5'd2, data: 32'd20});
    pulse_start();
    check("t3_fail_cleared", fail_valid, 64'd0);
    commit(5'd1, 32'd10);
    commit(5'd0, 32'h1234);
    commit(5'd2, 32'd20);
    check("t3_done", done, 64'd1);
    check("t3_pass", pass, 64'd1);
    check("t3_commits", commit_count, 64'd2);
    commit(5'd3, 32'd5);
    check("t3_done_ignored_mm", mismatch_count, 64'd0);
    check("t3_done_ignored_cc", commit_count, 64'd2);

    // 3b: unexpected commit on an empty FIFO is checked before DONE
    pulse_start();
    commit(5'd4, 32'd9);
    check("t3b_still_run", done, 64'd0);
    check("t3b_mismatch", mismatch_count, 64'd1);
    check("t3b_fail_rd", fail_rd, 64'd4);
    check("t3b_fail_exp", fail_exp, 64'd0);
    check("t3b_fail_act", fail_act, 64'd9);
    tick();
    check("t3b_done", done, 64'd1);
    check("t3b_pass", pass, 64'd0);

    // 4: full FIFO, simultaneous commit and offer, then wrap-around drain
    do_reset();
    for (int i = 0; i < 16; i++) push('{rd: 5'(i + 1), data: 32'(100 + i)});
    check("t4_full", exp_ready, 64'd0);
    pulse_start();
    exp_valid = 1'b1; exp_rd = 5'd31; exp_data = 32'hDEAD;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd100;
    #1;
    check("t4_full_same_cycle", exp_ready, 64'd0);
    tick();
    exp_valid = 1'b0; wb_valid = 1'b0;
    check("t4_ready_after_pop", exp_ready, 64'd1);
    check("t4_commits_1", commit_count, 64'd1);
    push('{rd: 5'd17, data: 32'd200});
    check("t4_full_again", exp_ready, 64'd0);
    exp_last = 1'b1;
    for (int i = 1; i < 16; i++) commit(5'(i + 1), 32'(100 + i));
    commit(5'd17, 32'd200);
    check("t4_done", done, 64'd1);
    check("t4_pass", pass, 64'd1);
    check("t4_commits", commit_count, 64'd17);
    check("t4_mismatch", mismatch_count, 64'd0);

    // 5: timeout 64 cycles after the last commit
    do_reset();
    push('{rd: 5'd1, data: 32'd1});
    push('{rd: 5'd2, data: 32'd2});
    pulse_start();
    commit(5'd1, 32'd1);
    check("t5_commits", commit_count, 64'd1);
    repeat (63) tick();
    check("t5_no_timeout_63", timeout, 64'd0);
    check("t5_not_done_63", done, 64'd0);
    tick();
    check("t5_timeout", timeout, 64'd1);
    check("t5_done", done, 64'd1);
    check("t5_pass", pass, 64'd0);
    check("t5_mismatch", mismatch_count, 64'd0);

    // 6: stall/flush counting, then reset mid-RUN
    do_reset();
    push('{rd: 5'd1, data: 32'd1});
    pulse_start();
    stall = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    check("t6_stall", stall_count, 64'd1);
    check("t6_flush", flush_count, 64'd2);
    check("t6_cycles", cycle_count, 64'd3);
    reset = 1'b1;
    #2;
    check("t6_rst_stall", stall_count, 64'd0);
    check("t6_rst_flush", flush_count, 64'd0);
    check("t6_rst_cycles", cycle_count, 64'd0);
    check("t6_rst_ready", exp_ready, 64'd1);
    check("t6_rst_done", done, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    commit(5'd1, 32'd1);
    tick();
    check("t6_idle_commits", commit_count, 64'd0);
    check("t6_idle_mismatch", mismatch_count, 64'd0);
    check("t6_idle_cycles", cycle_count, 64'd0);
    exp_last = 1'b1;
    pulse_start();
    tick();
    check("t6_fifo_flushed_done", done, 64'd1);
    check("t6_fifo_flushed_pass", pass, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
